input_conditioner: RTL and testbench
====================================

# input_conditioner

Multi-channel push-button / control-line conditioner: synchronises each asynchronous input, debounces it, and turns the clean level into single-cycle press and release pulses, with optional per-channel auto-repeat (typematic) of the press pulse while the input is held. It sits between the board buttons (or any slow external control lines) and the game logic. It replaces the per-bit synchroniser + edge-detector pairs with one parametrised block.

## Interface
- `CHANNELS`, 4: number of independent input channels.
- `SYNC_STAGES`, 3: flip-flop depth of each synchroniser chain; must be ≥ 2.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles needed to accept a new level (10 ms at 50 MHz); must be ≥ 1.
- `REPEAT_DELAY`, 25000000: cycles from the initial press pulse to the first repeat pulse; must be ≥ 1.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat pulses; must be ≥ 1.
- `REPEAT_MASK`, {CHANNELS{1'b0}}: bit i = 1 enables auto-repeat on channel i.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state immediately.
- `in`  in  CHANNELS  raw asynchronous inputs, active-high.
- `level`  out  CHANNELS  debounced level per channel.
- `press`  out  CHANNELS  one-cycle pulse on accepted 0→1, plus repeat pulses.
- `release`  out  CHANNELS  one-cycle pulse on accepted 1→0.

## Operation
- Channels are fully independent; no cross-channel interaction.
- Synchroniser: SYNC_STAGES-deep shift chain per bit, all stages reset to 0; `s[i]` is the last stage.
- Debounce: per-channel counter, width $clog2(DEBOUNCE_CYCLES+1).
  - `s[i] == level[i]`: counter ← 0.
  - `s[i] != level[i]` and counter < DEBOUNCE_CYCLES−1: counter ← counter+1.
  - `s[i] != level[i]` and counter == DEBOUNCE_CYCLES−1: `level[i]` ← `s[i]`, counter ← 0.
  - Any glitch back to the current level restarts the count from 0.
- Edge pulses (registered): `press[i]` high for the one cycle after `level[i]` rises; `release[i]` high for the one cycle after it falls.
- Repeat FSM per channel (present only where REPEAT_MASK[i] = 1; elsewhere tied to IDLE), counter width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1):
  - IDLE: on `level[i]` rising → DELAY, counter ← 0.
  - DELAY: counter increments each cycle; on counter == REPEAT_DELAY−1 → pulse `press[i]`, counter ← 0, go REPEAT.
  - REPEAT: counter increments; on counter == REPEAT_PERIOD−1 → pulse `press[i]`, counter ← 0.
  - DELAY/REPEAT: `level[i]` falling → IDLE, counter ← 0; release pulse only, no repeat pulse in that cycle (release wins).
- Reset values: `level`, `press`, `release` = 0; all counters 0; all FSMs IDLE. An input held high through reset is seen as a fresh press after the full latency.

## Timing
- Edge 1 is the first `clk` rising edge after `in[i]` changes, with `in[i]` meeting setup.
- `level[i]` updates on edge SYNC_STAGES + DEBOUNCE_CYCLES if the input stays stable.
- `press[i]`/`release[i]` are high during the cycle that follows that edge, i.e. coincident with the new `level[i]` value, for exactly one cycle.
- First repeat pulse falls exactly REPEAT_DELAY cycles after the initial press pulse; later pulses every REPEAT_PERIOD cycles.
- A pulse can never be wider than one cycle; `press[i]` and `release[i]` are never high together.
- `rst` assertion clears outputs asynchronously, mid-pulse or mid-count; deassertion is synchronous to `clk` outside this block.

## Test plan
Bench parameters: CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_MASK=2'b10.
- Clean press: `in[0]` 0→1 before edge 1 and held → `level[0]` = 1 after edge 6; `press[0]` high only during cycle 6–7; no further `press[0]` (repeat disabled).
- Bounce: `in[0]` high for 3 cycles, low 1, then high and held → the 3-cycle burst produces no pulse; the count restarts and `level[0]` rises 6 edges after the final rising edge.
- Auto-repeat: hold `in[1]`; initial `press[1]` at cycle P → further pulses at P+10, P+13, P+16. Release → single `release[1]` pulse, no press pulse in that cycle, FSM back to IDLE.
- Simultaneous channels: both inputs rise on the same edge → both `press` bits pulse in the same cycle; only channel 1 repeats.
- Reset mid-operation: assert `rst` while channel 1 is in REPEAT with `level` = 2'b11 → all outputs 0 immediately. Deassert with inputs still high → new `press` pulses 6 edges later.
- Short glitch: a 1-cycle high on `in[0]` → `level`, `press` and `release` stay 0.

Source files
------------

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: per-bit synchroniser, debounce, registered
// press/release edge pulses and optional typematic auto-repeat of press.
module input_conditioner #(
    parameter int                  CHANNELS        = 4,
    parameter int                  SYNC_STAGES     = 3,
    parameter int                  DEBOUNCE_CYCLES = 500000,
    parameter int                  REPEAT_DELAY    = 25000000,
    parameter int                  REPEAT_PERIOD   = 5000000,
    parameter logic [CHANNELS-1:0] REPEAT_MASK     = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic [DW-1:0]          db_cnt_q, db_cnt_d;
            logic                   level_q, level_d;
            logic                   press_q, press_d;
            logic                   rel_q, rel_d;
            logic                   rise, fall, rep_pulse;

            always_comb begin
                sync_d   = {sync_q[SYNC_STAGES-2:0], in[gi]};
                db_cnt_d = '0;
                level_d  = level_q;
                // Any sample matching the current level leaves the count at 0.
                if (sync_q[SYNC_STAGES-1] != level_q) begin
                    if (db_cnt_q == DB_LAST) begin
                        level_d = sync_q[SYNC_STAGES-1];
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
                rise    = level_d & ~level_q;
                fall    = ~level_d & level_q;
                press_d = rise | rep_pulse;
                rel_d   = fall;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q   <= '0;
                    db_cnt_q <= '0;
                    level_q  <= 1'b0;
                    press_q  <= 1'b0;
                    rel_q    <= 1'b0;
                end else begin
                    sync_q   <= sync_d;
                    db_cnt_q <= db_cnt_d;
                    level_q  <= level_d;
                    press_q  <= press_d;
                    rel_q    <= rel_d;
                end
            end

            if (REPEAT_MASK[gi]) begin : g_repeat
                typedef enum logic [1:0] {
                    IDLE   = 2'd0,
                    DELAY  = 2'd1,
                    REPEAT = 2'd2
                } rep_state_t;

                localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
                localparam int RW      = $clog2(REP_MAX + 1);
                localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
                localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

                rep_state_t    state_q, state_d;
                logic [RW-1:0] rep_cnt_q, rep_cnt_d;

                always_comb begin
                    state_d   = state_q;
                    rep_cnt_d = rep_cnt_q;
                    rep_pulse = 1'b0;
                    case (state_q)
                        IDLE: begin
                            if (rise) begin
                                state_d   = DELAY;
                                rep_cnt_d = '0;
                            end
                        end
                        DELAY, REPEAT: begin
                            // A falling level suppresses any repeat due in the same cycle.
                            if (fall) begin
                                state_d   = IDLE;
                                rep_cnt_d = '0;
                            end else if (rep_cnt_q == ((state_q == DELAY) ? RD_LAST : RP_LAST)) begin
                                rep_pulse = 1'b1;
                                rep_cnt_d = '0;
                                state_d   = REPEAT;
                            end else begin
                                rep_cnt_d = rep_cnt_q + 1'b1;
                            end
                        end
                        default: begin
                            state_d   = IDLE;
                            rep_cnt_d = '0;
                        end
                    endcase
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        state_q   <= IDLE;
                        rep_cnt_q <= '0;
                    end else begin
                        state_q   <= state_d;
                        rep_cnt_q <= rep_cnt_d;
                    end
                end
            end else begin : g_no_repeat
                assign rep_pulse = 1'b0;
            end

            assign level[gi]         = level_q;
            assign press[gi]         = press_q;
            assign release_pulse[gi] = rel_q;
        end
    endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: window-based debounce/repeat model checked every
// cycle, plus directed literal expectations from the hand-worked timing.
module tb_input_conditioner;
    localparam int CH   = 2;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam logic [1:0] MASK = 2'b10;
    localparam int L    = SYNC + DEB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] in_r = 2'b00;
    logic [1:0] level, press, rel;

    int checks = 0;
    int errors = 0;

    input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk), .rst(rst), .in(in_r),
        .level(level), .press(press), .release_pulse(rel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
        end else begin
            $display("ok   %s t=%0t value=%b", name, $time, act);
        end
    endtask

    // Model: a level flips once the DEB most recent synchronised samples all
    // disagree with it; repeats fall RD, RD+RP, ... edges after the rising edge.
    bit         mq [CH][L];
    logic [1:0] m_level;
    int         last_rise [CH];
    int         ecount;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            for (int j = 0; j < L; j++) mq[c][j] = 1'b0;
            last_rise[c] = -1000;
        end
        m_level = 2'b00;
        ecount  = 0;
    endtask

    task automatic model_step(output logic [1:0] e_press, output logic [1:0] e_rel);
        ecount++;
        e_press = 2'b00;
        e_rel   = 2'b00;
        for (int c = 0; c < CH; c++) begin
            bit all_diff;
            logic newl;
            for (int j = L - 1; j > 0; j--) mq[c][j] = mq[c][j-1];
            mq[c][0] = in_r[c];
            all_diff = 1'b1;
            for (int j = SYNC; j < L; j++) if (mq[c][j] == m_level[c]) all_diff = 1'b0;
            newl = all_diff ? ~m_level[c] : m_level[c];
            if (newl && !m_level[c]) begin
                e_press[c]   = 1'b1;
                last_rise[c] = ecount;
            end
            if (!newl && m_level[c]) e_rel[c] = 1'b1;
            if (MASK[c] && newl && m_level[c] && (ecount - last_rise[c]) >= RD &&
                ((ecount - last_rise[c] - RD) % RP) == 0)
                e_press[c] = 1'b1;
            m_level[c] = newl;
        end
    endtask

    initial begin
        logic [1:0] e_press, e_rel;
        model_reset();
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                model_reset();
                e_press = 2'b00;
                e_rel   = 2'b00;
            end else begin
                model_step(e_press, e_rel);
            end
            checks++;
            if (level !== m_level || press !== e_press || rel !== e_rel) begin
                errors++;
                $display("FAIL model t=%0t actual lvl/prs/rel=%b/%b/%b expected=%b/%b/%b",
                         $time, level, press, rel, m_level, e_press, e_rel);
            end
            if ((press & rel) != 2'b00) begin
                errors++;
                $display("FAIL overlap t=%0t press=%b release=%b required disjoint", $time, press, rel);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("reset_level", level, 2'b00);
        chk("reset_press", press, 2'b00);
        chk("reset_rel", rel, 2'b00);
        rst = 1'b0;
        tick(2);

        // Clean press on channel 0
        in_r = 2'b01;
        tick(5);
        chk("clean_lvl_e5", level, 2'b00);
        tick(1);
        chk("clean_lvl_e6", level, 2'b01);
        chk("clean_prs_e6", press, 2'b01);
        tick(1);
        chk("clean_prs_e7", press, 2'b00);
        tick(20);
        chk("clean_norep", press, 2'b00);
        in_r = 2'b00;
        tick(6);
        chk("clean_rel", rel, 2'b01);
        chk("clean_rel_lvl", level, 2'b00);
        tick(3);

        // Bounce: 3 high, 1 low, then held
        in_r = 2'b01;
        tick(3);
        in_r = 2'b00;
        tick(1);
        in_r = 2'b01;
        tick(5);
        chk("bounce_lvl_e5", level, 2'b00);
        tick(1);
        chk("bounce_prs_e6", press, 2'b01);
        in_r = 2'b00;
        tick(10);

        // Auto-repeat on channel 1, release coinciding with a repeat slot
        in_r = 2'b10;
        tick(6);
        chk("rep_P", press, 2'b10);
        tick(10);
        chk("rep_P10", press, 2'b10);
        tick(1);
        chk("rep_P11", press, 2'b00);
        tick(2);
        chk("rep_P13", press, 2'b10);
        tick(3);
        chk("rep_P16", press, 2'b10);
        in_r = 2'b00;
        tick(3);
        chk("rep_P19", press, 2'b10);
        tick(3);
        chk("rep_P22_rel", rel, 2'b10);
        chk("rep_P22_prs", press, 2'b00);
        tick(15);
        chk("rep_idle", press, 2'b00);

        // Both channels together, then reset mid-repeat
        in_r = 2'b11;
        tick(6);
        chk("sim_P", press, 2'b11);
        tick(10);
        chk("sim_P10", press, 2'b10);
        tick(3);
        chk("sim_P13", press, 2'b10);
        chk("sim_lvl", level, 2'b11);
        tick(1);
        rst = 1'b1;
        #1;
        chk("async_lvl", level, 2'b00);
        chk("async_prs", press, 2'b00);
        chk("async_rel", rel, 2'b00);
        tick(3);
        rst = 1'b0;
        tick(5);
        chk("post_rst_e5", press, 2'b00);
        tick(1);
        chk("post_rst_e6", press, 2'b11);
        in_r = 2'b00;
        tick(12);

        // One-cycle glitch
        in_r = 2'b01;
        tick(1);
        in_r = 2'b00;
        tick(10);
        chk("glitch_lvl", level, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
